// File: rtl/pc_gen_unit.sv
// ============================================================================
// pc_gen_unit : fetch PC register with trap/redirect/RAS/sequential next-PC
//               selection, stall hold and misalignment flag
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 32,
  parameter int              INC_BYTES    = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    if (IALIGN == 16) return addr[0];
    else              return |addr[1:0];
  endfunction

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             misaligned_q, misaligned_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];

  logic             ras_wr_en;
  logic [PTR_W-1:0] ras_wr_idx;
  logic             do_pop;

  assign current_pc  = pc_q;
  assign pc_plus_inc = pc_q + XLEN'(INC_BYTES);
  assign misaligned  = misaligned_q;
  assign ras_empty   = (count_q == '0);
  assign ras_full    = (count_q == CNT_W'(RAS_DEPTH));
  assign do_pop      = ras_pop && !ras_empty;

  always_comb begin
    pc_d       = pc_q;
    top_d      = top_q;
    count_d    = count_q;
    ras_wr_en  = 1'b0;
    ras_wr_idx = top_q;
    if (trap_valid) begin
      pc_d    = trap_vector;
      count_d = '0;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (pc_write) begin
      if (do_pop && ras_push) begin
        // Return and call together: consume the top, then reuse its slot.
        pc_d      = ras_mem_q[top_q];
        ras_wr_en = 1'b1;
      end else if (do_pop) begin
        pc_d    = ras_mem_q[top_q];
        top_d   = top_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end else begin
        pc_d = pc_plus_inc;
        if (ras_push) begin
          // When full, top+1 is the oldest slot, giving a circular overwrite.
          top_d      = top_q + PTR_W'(1);
          ras_wr_en  = 1'b1;
          ras_wr_idx = top_q + PTR_W'(1);
          if (!ras_full) count_d = count_q + CNT_W'(1);
        end
      end
    end
    misaligned_d = is_misaligned(pc_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= is_misaligned(RESET_VECTOR);
      top_q        <= '0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      top_q        <= top_d;
      count_q      <= count_d;
    end
  end

  // Entry contents need no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (ras_wr_en) ras_mem_q[ras_wr_idx] <= ras_push_addr;
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
// ============================================================================
// tb_pc_gen_unit : directed and randomized checks of pc_gen_unit against a
//                  queue-based next-PC / return-stack model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ras_push = 1'b0;
  logic [31:0] ras_push_addr = '0;
  logic        ras_pop = 1'b0;

  logic [31:0] current_pc, pc_plus_inc;
  logic        misaligned, ras_empty, ras_full;
  logic [31:0] current_pc16, pc_plus_inc16;
  logic        misaligned16, ras_empty16, ras_full16;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] ras[$];
  string       step_tag = "init";

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .current_pc(current_pc), .pc_plus_inc(pc_plus_inc), .misaligned(misaligned),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  pc_gen_unit #(.IALIGN(16), .INC_BYTES(2)) dut16 (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .current_pc(current_pc16), .pc_plus_inc(pc_plus_inc16), .misaligned(misaligned16),
    .ras_empty(ras_empty16), .ras_full(ras_full16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic tv, input logic [31:0] tvec,
                       input logic rv, input logic [31:0] rpc,
                       input logic push, input logic [31:0] paddr, input logic pop);
    pc_write = pw; trap_valid = tv; trap_vector = tvec;
    redirect_valid = rv; redirect_pc = rpc;
    ras_push = push; ras_push_addr = paddr; ras_pop = pop;
  endtask

  // Model the architectural rules, clock once, compare every output.
  task automatic step(input string tag);
    logic [31:0] npc;
    bit          dpop;
    step_tag = tag;
    if (trap_valid) begin
      npc = trap_vector;
      ras.delete();
    end else if (redirect_valid) begin
      npc = redirect_pc;
    end else if (!pc_write) begin
      npc = m_pc;
    end else begin
      dpop = ras_pop && (ras.size() > 0);
      if (dpop && ras_push) begin
        npc = ras[ras.size()-1];
        ras[ras.size()-1] = ras_push_addr;
      end else if (dpop) begin
        npc = ras.pop_back();
      end else begin
        npc = m_pc + 32'd4;
        if (ras_push) begin
          if (ras.size() == DEPTH) void'(ras.pop_front());
          ras.push_back(ras_push_addr);
        end
      end
    end
    m_pc = npc;
    @(posedge clk); #1;
    chk({tag, "_pc"},    current_pc,  m_pc);
    chk({tag, "_inc"},   pc_plus_inc, m_pc + 32'd4);
    chk({tag, "_mis"},   {31'd0, misaligned}, {31'd0, (m_pc[1:0] != 2'b00)});
    chk({tag, "_empty"}, {31'd0, ras_empty},  {31'd0, (ras.size() == 0)});
    chk({tag, "_full"},  {31'd0, ras_full},   {31'd0, (ras.size() == DEPTH)});
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    ras.delete();
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_pc", current_pc, 32'h0);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_full", {31'd0, ras_full}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Asynchronous reset mid-run
    drive(1, 0, 0, 0, 0, 1, 32'h700, 0);
    step("pre1");
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("pre2");
    #3 rst = 1'b1;
    #1;
    chk("async_rst_pc", current_pc, 32'h0);
    chk("async_rst_empty", {31'd0, ras_empty}, 32'd1);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    step("seq1");
    step("seq2");
    step("seq3");
    chk("seq3_pc_const", current_pc, 32'hC);
    chk("seq3_inc_const", pc_plus_inc, 32'h10);
    step("seq4");

    // Stall, then redirect during stall (RAS ops ignored while stalled)
    drive(0, 0, 0, 0, 0, 1, 32'h123, 0);
    step("stall1");
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step("stall2");
    chk("stall_hold_const", current_pc, 32'h10);
    drive(0, 0, 0, 1, 32'h200, 0, 0, 0);
    step("redir_stall");
    chk("redir_stall_const", current_pc, 32'h200);

    // Priority: trap beats redirect and pop, flushes RAS
    drive(1, 0, 0, 0, 0, 1, 32'h500, 0);
    step("push500");
    drive(0, 1, 32'h100, 1, 32'h300, 0, 0, 1);
    step("trap");
    chk("trap_const", current_pc, 32'h100);
    chk("trap_empty_const", {31'd0, ras_empty}, 32'd1);

    // RAS push/pop and underflow
    drive(1, 0, 0, 0, 0, 1, 32'h44, 0); step("push44");
    drive(1, 0, 0, 0, 0, 1, 32'h88, 0); step("push88");
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    step("pop1"); chk("pop1_const", current_pc, 32'h88);
    step("pop2"); chk("pop2_const", current_pc, 32'h44);
    step("pop3_empty"); chk("pop3_const", current_pc, 32'h48);

    // Overflow wraps over the oldest entry
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 1, 32'hA + i, 0);
      step("fill");
    end
    chk("full_const", {31'd0, ras_full}, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step("drain");
      chk("drain_const", current_pc, 32'hE - i);
    end

    // Misalignment for both alignment settings and address wrap
    drive(1, 0, 0, 1, 32'h202, 0, 0, 0);
    step("mis202");
    chk("mis16_202", {31'd0, misaligned16}, 32'd0);
    drive(1, 0, 0, 1, 32'h201, 0, 0, 0);
    step("mis201");
    chk("mis16_201", {31'd0, misaligned16}, 32'd1);
    drive(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step("wrap_pre");
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("wrap");
    chk("wrap_const", current_pc, 32'h0);

    // Push and pop in the same cycle
    drive(1, 0, 0, 0, 0, 1, 32'h44, 0); step("pp_push44");
    drive(1, 0, 0, 0, 0, 1, 32'h90, 1); step("pp_both");
    chk("pp_both_const", current_pc, 32'h44);
    drive(1, 0, 0, 0, 0, 0, 0, 1); step("pp_pop");
    chk("pp_pop_const", current_pc, 32'h90);
    drive(1, 0, 0, 0, 0, 1, 32'h60, 1); step("pp_empty_push");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(3) != 0,
            $urandom_range(15) == 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(7) == 0,
            ($urandom & 32'hFFFF_FFFC) | (($urandom_range(5) == 0) ? 32'h2 : 32'h0),
            $urandom_range(2) == 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(2) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
